id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and datapath width.
REQ-002 SHALL have parameter RA_W, default 5, meaning register address width; the register file holds 2**RA_W entries.
REQ-003 SHALL have ports clk input 1 (clock) and rst input 1 (reset): one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports in_valid input 1 (IF/ID valid), ir input 32 (instruction), next_pc input DATA_W (PC+4), branch input 1 (beq decoded).
REQ-005 SHALL have ports wb_en input 1, wb_reg input RA_W and wb_data input DATA_W (write-back port).
REQ-006 SHALL have ports ex_regwrite input 1, ex_memread input 1 and ex_dest input RA_W (instruction in EX).
REQ-007 SHALL have ports mem_regwrite input 1, mem_dest input RA_W and mem_result input DATA_W (instruction in MEM).
REQ-008 SHALL have ports pc_src output 1, beq_adr output DATA_W, jmp_adr output 26, stall output 1 (hold PC and IF/ID) and flush output 1 (kill IF/ID).
REQ-009 SHALL have registered ports ex_valid output 1, ex_rd1 and ex_rd2 output DATA_W, ex_imm output DATA_W, ex_rs, ex_rt and ex_rd output RA_W, ex_opcode and ex_func output 6.

Function
REQ-010 SHALL decode fields as: rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], imm=sign-extend ir[15:0] to DATA_W, jmp_adr=ir[25:0], opcode=ir[31:26], func=ir[5:0]; for RA_W other than 5, SHALL take the low RA_W bits of each 5-bit field.
REQ-011 SHALL compute beq_adr=next_pc+(imm<<2), modulo 2**DATA_W, with wrap-around permitted.
REQ-012 Register file: SHALL write on the clk rising edge when wb_en=1 and wb_reg!=0.
REQ-013 Register file: entry 0 SHALL always read 0.
REQ-014 Register file: SHALL be write-first; a read of wb_reg while wb_en=1 and wb_reg!=0 SHALL return wb_data in the same cycle.
REQ-015 Load-use hazard: SHALL assert stall when in_valid=1, ex_memread=1, ex_dest!=0 and ex_dest equals rs or rt.
REQ-016 Branch hazard: SHALL assert stall when in_valid=1, branch=1, ex_regwrite=1, ex_dest!=0 and ex_dest equals rs or rt.
REQ-017 stall SHALL be combinational, with no latency.
REQ-018 pc_src SHALL equal in_valid & branch & !stall & (op1==op2), where op1 and op2 are the branch operands.
REQ-019 flush SHALL equal pc_src, held for the one cycle of the branch; the branch itself SHALL proceed into ID/EX.
REQ-020 ID/EX register: on each rising edge, if in_valid=0 or stall=1, SHALL load a bubble: ex_valid=0 and all other ex_* outputs 0.
REQ-021 ID/EX register: otherwise SHALL load ex_valid=1 together with the current decoded fields and the register-file read data.
REQ-022 Decode-to-ex_* latency SHALL be exactly 1 cycle.
REQ-023 If a stall condition and a write-back to the same register occur in the same cycle, SHALL stall and apply the write; the retried decode SHALL read the new value.

Reset
REQ-024 While rst=0, SHALL asynchronously clear all register-file entries and all ex_* outputs to 0, including ex_valid=0.
REQ-025 Reset asserted mid-stall SHALL discard any pending bubble or retry state.
REQ-026 The first rising edge after rst returns to 1 SHALL decode normally.

Configuration
REQ-027 Macro ID_BRANCH_FWD_EN SHALL select whether branch operands are forwarded from MEM.
REQ-028 With ID_BRANCH_FWD_EN defined: each branch operand SHALL be mem_result when mem_regwrite=1, mem_dest!=0 and mem_dest equals that source register; otherwise it SHALL be the register-file value.
REQ-029 Without ID_BRANCH_FWD_EN: branch operands SHALL come from the register file only.
REQ-030 Without ID_BRANCH_FWD_EN: stall SHALL additionally assert when in_valid=1, branch=1, mem_regwrite=1, mem_dest!=0 and mem_dest equals rs or rt.

Verification
REQ-031 Write-first check: wb_en=1, wb_reg=3, wb_data=0x55 while ir reads rs=3 -> next cycle ex_rd1=0x55 and ex_valid=1.
REQ-032 Load-use check: ex_memread=1, ex_dest=8, ir rt=8 -> stall=1 for 1 cycle, then the bubble shows ex_valid=0; after ex_memread=0 the same ir passes with ex_valid=1.
REQ-033 Taken-branch check: beq with rs=rt=2, imm=0xFFFF, next_pc=0x100 -> pc_src=1, flush=1, beq_adr=0xFC.
REQ-034 Forwarded-branch check: mem_regwrite=1, mem_dest=4, mem_result=7, register 5 holds 7, beq rs=4 rt=5 -> pc_src=1 with ID_BRANCH_FWD_EN; without it, stall=1 and pc_src=0.
REQ-035 Register-0 check: wb_en=1, wb_reg=0, wb_data=0xFFFFFFFF, then read rs=0 -> ex_rd1=0.
REQ-036 Reset-mid-operation check: drop rst to 0 during a load-use stall -> all ex_*=0 at once; after rst returns to 1, the next edge loads a valid decode.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - IF/ID, hazard, write-back and ID/EX signal bundle for id_stage_pipe
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    // IF/ID side
    logic              in_valid;
    logic [31:0]       ir;
    logic [DATA_W-1:0] next_pc;
    logic              branch;
    // write-back port
    logic              wb_en;
    logic [RA_W-1:0]   wb_reg;
    logic [DATA_W-1:0] wb_data;
    // instruction currently in EX
    logic              ex_regwrite;
    logic              ex_memread;
    logic [RA_W-1:0]   ex_dest;
    // instruction currently in MEM
    logic              mem_regwrite;
    logic [RA_W-1:0]   mem_dest;
    logic [DATA_W-1:0] mem_result;
    // control back to fetch
    logic              pc_src;
    logic [DATA_W-1:0] beq_adr;
    logic [25:0]       jmp_adr;
    logic              stall;
    logic              flush;
    // ID/EX register
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [RA_W-1:0]   ex_rs;
    logic [RA_W-1:0]   ex_rt;
    logic [RA_W-1:0]   ex_rd;
    logic [5:0]        ex_opcode;
    logic [5:0]        ex_func;

    modport master (
        output in_valid, ir, next_pc, branch,
        output wb_en, wb_reg, wb_data,
        output ex_regwrite, ex_memread, ex_dest,
        output mem_regwrite, mem_dest, mem_result,
        input  pc_src, beq_adr, jmp_adr, stall, flush,
        input  ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_opcode, ex_func
    );

    modport slave (
        input  in_valid, ir, next_pc, branch,
        input  wb_en, wb_reg, wb_data,
        input  ex_regwrite, ex_memread, ex_dest,
        input  mem_regwrite, mem_dest, mem_result,
        output pc_src, beq_adr, jmp_adr, stall, flush,
        output ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_opcode, ex_func
    );
endinterface

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined decode stage: register file, hazard stall, early beq resolve, ID/EX register (optional macro ID_BRANCH_FWD_EN)
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input logic          clk,
    input logic          rst,
    id_stage_pipe_if.slave bus
);
    localparam int NREG = 2 ** RA_W;

    logic [DATA_W-1:0] rf [NREG];

    logic [4:0]        rs5, rt5, rd5;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [DATA_W-1:0] imm;
    logic [5:0]        opcode, func;
    logic              wb_write;
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] op1, op2;
    logic              load_use, br_ex_haz, br_mem_haz;
    logic              stall_i, pc_src_i;

    // Instruction field extraction; narrower register files use the low bits of each field.
    assign rs5    = bus.ir[25:21];
    assign rt5    = bus.ir[20:16];
    assign rd5    = bus.ir[15:11];
    assign rs     = RA_W'(rs5);
    assign rt     = RA_W'(rt5);
    assign rd     = RA_W'(rd5);
    assign imm    = DATA_W'($signed(bus.ir[15:0]));
    assign opcode = bus.ir[31:26];
    assign func   = bus.ir[5:0];

    assign bus.jmp_adr = bus.ir[25:0];
    assign bus.beq_adr = bus.next_pc + (imm << 2);

    assign wb_write = bus.wb_en && (bus.wb_reg != '0);

    // Register file storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_write) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    // Write-first read ports: a same-cycle write-back bypasses the array.
    always_comb begin
        rd1 = rf[rs];
        rd2 = rf[rt];
        if (rs == '0) begin
            rd1 = '0;
        end else if (wb_write && (bus.wb_reg == rs)) begin
            rd1 = bus.wb_data;
        end
        if (rt == '0) begin
            rd2 = '0;
        end else if (wb_write && (bus.wb_reg == rt)) begin
            rd2 = bus.wb_data;
        end
    end

    // A load in EX cannot feed anything; an ALU result in EX cannot feed a branch compare.
    assign load_use  = bus.in_valid && bus.ex_memread && (bus.ex_dest != '0) &&
                       ((bus.ex_dest == rs) || (bus.ex_dest == rt));
    assign br_ex_haz = bus.in_valid && bus.branch && bus.ex_regwrite && (bus.ex_dest != '0) &&
                       ((bus.ex_dest == rs) || (bus.ex_dest == rt));

`ifdef ID_BRANCH_FWD_EN
    // Branch operands take the MEM result when it targets the source register.
    always_comb begin
        op1 = rd1;
        op2 = rd2;
        if (bus.mem_regwrite && (bus.mem_dest != '0) && (bus.mem_dest == rs)) begin
            op1 = bus.mem_result;
        end
        if (bus.mem_regwrite && (bus.mem_dest != '0) && (bus.mem_dest == rt)) begin
            op2 = bus.mem_result;
        end
    end
    assign br_mem_haz = 1'b0;
`else
    // Without a MEM bypass the branch waits until the producer has written back.
    always_comb begin
        op1 = rd1;
        op2 = rd2;
    end
    assign br_mem_haz = bus.in_valid && bus.branch && bus.mem_regwrite && (bus.mem_dest != '0) &&
                        ((bus.mem_dest == rs) || (bus.mem_dest == rt));
    logic unused_mem_result;
    assign unused_mem_result = ^bus.mem_result;
`endif

    assign stall_i  = load_use || br_ex_haz || br_mem_haz;
    assign pc_src_i = bus.in_valid && bus.branch && !stall_i && (op1 == op2);

    assign bus.stall  = stall_i;
    assign bus.pc_src = pc_src_i;
    assign bus.flush  = pc_src_i;

    // ID/EX register: a bubble on invalid input or stall, otherwise the decoded instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_rd1    <= '0;
            bus.ex_rd2    <= '0;
            bus.ex_imm    <= '0;
            bus.ex_rs     <= '0;
            bus.ex_rt     <= '0;
            bus.ex_rd     <= '0;
            bus.ex_opcode <= '0;
            bus.ex_func   <= '0;
        end else if (!bus.in_valid || stall_i) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_rd1    <= '0;
            bus.ex_rd2    <= '0;
            bus.ex_imm    <= '0;
            bus.ex_rs     <= '0;
            bus.ex_rt     <= '0;
            bus.ex_rd     <= '0;
            bus.ex_opcode <= '0;
            bus.ex_func   <= '0;
        end else begin
            bus.ex_valid  <= 1'b1;
            bus.ex_rd1    <= rd1;
            bus.ex_rd2    <= rd2;
            bus.ex_imm    <= imm;
            bus.ex_rs     <= rs;
            bus.ex_rt     <= rt;
            bus.ex_rd     <= rd;
            bus.ex_opcode <= opcode;
            bus.ex_func   <= func;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed table-driven bench for id_stage_pipe
module tb_id_stage_pipe;
    logic clk;
    logic rst;

    id_stage_pipe_if #(.DATA_W(32), .RA_W(5)) bus ();

    id_stage_pipe #(.DATA_W(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic        branch;
        logic [31:0] ir;
        logic [31:0] next_pc;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        ex_regwrite;
        logic        ex_memread;
        logic [4:0]  ex_dest;
        logic        mem_regwrite;
        logic [4:0]  mem_dest;
        logic [31:0] mem_result;
        logic        e_stall;
        logic        e_pc_src;
        logic [31:0] e_beq_adr;
        logic        e_valid;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
    } vec_t;

    vec_t vecs [16];
    int   nvec;
    int   checks;
    int   errors;

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        v.in_valid = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] r_ins(logic [5:0] op, logic [4:0] s, logic [4:0] t,
                                          logic [4:0] d, logic [5:0] fn);
        return {op, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] s, logic [4:0] t,
                                          logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid     = v.in_valid;
        bus.branch       = v.branch;
        bus.ir           = v.ir;
        bus.next_pc      = v.next_pc;
        bus.wb_en        = v.wb_en;
        bus.wb_reg       = v.wb_reg;
        bus.wb_data      = v.wb_data;
        bus.ex_regwrite  = v.ex_regwrite;
        bus.ex_memread   = v.ex_memread;
        bus.ex_dest      = v.ex_dest;
        bus.mem_regwrite = v.mem_regwrite;
        bus.mem_dest     = v.mem_dest;
        bus.mem_result   = v.mem_result;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic apply(input int idx, input vec_t v);
        logic [31:0] ir;
        ir = v.ir;
        drive(v);
        @(negedge clk);
        chk($sformatf("v%0d stall", idx),   {31'd0, bus.stall},  {31'd0, v.e_stall});
        chk($sformatf("v%0d pc_src", idx),  {31'd0, bus.pc_src}, {31'd0, v.e_pc_src});
        chk($sformatf("v%0d flush", idx),   {31'd0, bus.flush},  {31'd0, v.e_pc_src});
        chk($sformatf("v%0d beq_adr", idx), bus.beq_adr, v.e_beq_adr);
        chk($sformatf("v%0d jmp_adr", idx), {6'd0, bus.jmp_adr}, {6'd0, ir[25:0]});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ex_valid", idx), {31'd0, bus.ex_valid}, {31'd0, v.e_valid});
        chk($sformatf("v%0d ex_rd1", idx), bus.ex_rd1, v.e_rd1);
        chk($sformatf("v%0d ex_rd2", idx), bus.ex_rd2, v.e_rd2);
        chk($sformatf("v%0d ex_imm", idx), bus.ex_imm, v.e_imm);
        if (v.e_valid) begin
            chk($sformatf("v%0d ex_rs", idx), {27'd0, bus.ex_rs}, {27'd0, ir[25:21]});
            chk($sformatf("v%0d ex_rt", idx), {27'd0, bus.ex_rt}, {27'd0, ir[20:16]});
            chk($sformatf("v%0d ex_rd", idx), {27'd0, bus.ex_rd}, {27'd0, ir[15:11]});
            chk($sformatf("v%0d ex_opcode", idx), {26'd0, bus.ex_opcode}, {26'd0, ir[31:26]});
            chk($sformatf("v%0d ex_func", idx), {26'd0, bus.ex_func}, {26'd0, ir[5:0]});
        end else begin
            chk($sformatf("v%0d ex_fields", idx),
                {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_opcode, bus.ex_func}, 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        nvec   = 0;

        // v0: write r2=0x11, no decode
        v = blank(); v.in_valid = 0; v.wb_en = 1; v.wb_reg = 2; v.wb_data = 32'h11;
        vecs[nvec++] = v;
        // v1: write r5=7, no decode
        v = blank(); v.in_valid = 0; v.wb_en = 1; v.wb_reg = 5; v.wb_data = 32'h7;
        vecs[nvec++] = v;
        // v2: write-first r3=0x55 read as rs
        v = blank(); v.wb_en = 1; v.wb_reg = 3; v.wb_data = 32'h55;
        v.ir = r_ins(6'd0, 5'd3, 5'd2, 5'd1, 6'h20); v.next_pc = 32'h40;
        v.e_beq_adr = 32'h20C0; v.e_valid = 1; v.e_rd1 = 32'h55; v.e_rd2 = 32'h11; v.e_imm = 32'h820;
        vecs[nvec++] = v;
        // v3: write to r0 is ignored, even for same-cycle bypass
        v = blank(); v.wb_en = 1; v.wb_reg = 0; v.wb_data = 32'hFFFF_FFFF;
        v.ir = r_ins(6'd0, 5'd0, 5'd3, 5'd4, 6'h22); v.next_pc = 32'h44;
        v.e_beq_adr = 32'h80CC; v.e_valid = 1; v.e_rd1 = 32'h0; v.e_rd2 = 32'h55; v.e_imm = 32'h2022;
        vecs[nvec++] = v;
        // v4: r0 after attempted write, negative immediate
        v = blank(); v.ir = i_ins(6'h08, 5'd0, 5'd0, 16'h8000); v.next_pc = 32'h1000;
        v.e_beq_adr = 32'hFFFE_1000; v.e_valid = 1; v.e_imm = 32'hFFFF_8000;
        vecs[nvec++] = v;
        // v5: load-use on rt=8 -> stall and bubble
        v = blank(); v.ex_memread = 1; v.ex_dest = 8;
        v.ir = i_ins(6'h23, 5'd3, 5'd8, 16'h0010); v.next_pc = 32'h48;
        v.e_stall = 1; v.e_beq_adr = 32'h88;
        vecs[nvec++] = v;
        // v6: same instruction once the load has moved on
        v.ex_memread = 0; v.e_stall = 0; v.e_valid = 1; v.e_rd1 = 32'h55; v.e_rd2 = 32'h0; v.e_imm = 32'h10;
        vecs[nvec++] = v;
        // v7: taken beq r2==r2 with backward offset
        v = blank(); v.branch = 1; v.ir = i_ins(6'h04, 5'd2, 5'd2, 16'hFFFF); v.next_pc = 32'h100;
        v.e_pc_src = 1; v.e_beq_adr = 32'hFC; v.e_valid = 1;
        v.e_rd1 = 32'h11; v.e_rd2 = 32'h11; v.e_imm = 32'hFFFF_FFFF;
        vecs[nvec++] = v;
        // v8: not-taken beq r2!=r3
        v = blank(); v.branch = 1; v.ir = i_ins(6'h04, 5'd2, 5'd3, 16'h0004); v.next_pc = 32'h200;
        v.e_beq_adr = 32'h210; v.e_valid = 1; v.e_rd1 = 32'h11; v.e_rd2 = 32'h55; v.e_imm = 32'h4;
        vecs[nvec++] = v;
        // v9: branch depends on ALU result in EX -> stall
        v = blank(); v.branch = 1; v.ex_regwrite = 1; v.ex_dest = 2;
        v.ir = i_ins(6'h04, 5'd2, 5'd2, 16'h0001); v.next_pc = 32'h300;
        v.e_stall = 1; v.e_beq_adr = 32'h304;
        vecs[nvec++] = v;
        // v10: same EX producer but not a branch -> no stall
        v = blank(); v.ex_regwrite = 1; v.ex_dest = 2;
        v.ir = r_ins(6'd0, 5'd2, 5'd3, 5'd7, 6'h20); v.next_pc = 32'h304;
        v.e_beq_adr = 32'hE384; v.e_valid = 1; v.e_rd1 = 32'h11; v.e_rd2 = 32'h55; v.e_imm = 32'h3820;
        vecs[nvec++] = v;
        // v11: branch operand produced in MEM
        v = blank(); v.branch = 1; v.mem_regwrite = 1; v.mem_dest = 4; v.mem_result = 32'h7;
        v.ir = i_ins(6'h04, 5'd4, 5'd5, 16'h0002); v.next_pc = 32'h400; v.e_beq_adr = 32'h408;
`ifdef ID_BRANCH_FWD_EN
        v.e_pc_src = 1; v.e_valid = 1; v.e_rd1 = 32'h0; v.e_rd2 = 32'h7; v.e_imm = 32'h2;
`else
        v.e_stall = 1;
`endif
        vecs[nvec++] = v;
        // v12: load-use stall while r6 is written back
        v = blank(); v.ex_memread = 1; v.ex_dest = 6; v.wb_en = 1; v.wb_reg = 6; v.wb_data = 32'h66;
        v.ir = i_ins(6'h23, 5'd6, 5'd9, 16'h0000); v.next_pc = 32'h500;
        v.e_stall = 1; v.e_beq_adr = 32'h500;
        vecs[nvec++] = v;
        // v13: retried decode sees the written value
        v.ex_memread = 0; v.wb_en = 0; v.e_stall = 0; v.e_valid = 1; v.e_rd1 = 32'h66;
        vecs[nvec++] = v;
        // v14: hazard pattern with in_valid low -> no stall, bubble
        v = blank(); v.in_valid = 0; v.ex_memread = 1; v.ex_dest = 6;
        v.ir = i_ins(6'h23, 5'd6, 5'd9, 16'h0000); v.next_pc = 32'h500; v.e_beq_adr = 32'h500;
        vecs[nvec++] = v;
        // v15: beq_adr wraps around
        v = blank(); v.ir = i_ins(6'h08, 5'd5, 5'd2, 16'h0002); v.next_pc = 32'hFFFF_FFFC;
        v.e_beq_adr = 32'h4; v.e_valid = 1; v.e_rd1 = 32'h7; v.e_rd2 = 32'h11; v.e_imm = 32'h2;
        vecs[nvec++] = v;

        rst = 1'b0;
        drive(blank());
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("reset ex_rd1", bus.ex_rd1, 32'd0);
        chk("reset ex_imm", bus.ex_imm, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            apply(i, vecs[i]);
        end

        // Reset asserted during a load-use stall
        v = blank(); v.ir = i_ins(6'h08, 5'd3, 5'd2, 16'h1234); v.next_pc = 32'h600;
        drive(v);
        @(posedge clk);
        #1;
        chk("pre-reset ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("pre-reset ex_rd2", bus.ex_rd2, 32'h11);
        v.ex_memread = 1; v.ex_dest = 3;
        drive(v);
        @(negedge clk);
        chk("pre-reset stall", {31'd0, bus.stall}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-stall reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("mid-stall reset ex_rd1", bus.ex_rd1, 32'd0);
        chk("mid-stall reset ex_rd2", bus.ex_rd2, 32'd0);
        chk("mid-stall reset ex_imm", bus.ex_imm, 32'd0);
        chk("mid-stall reset ex_fields",
            {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_opcode, bus.ex_func}, 32'd0);
        @(posedge clk);
        #1;
        chk("held reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        v.ex_memread = 0;
        drive(v);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("post-reset ex_rd1 cleared", bus.ex_rd1, 32'd0);
        chk("post-reset ex_rd2 cleared", bus.ex_rd2, 32'd0);
        chk("post-reset ex_imm", bus.ex_imm, 32'h1234);
        chk("post-reset ex_rs", {27'd0, bus.ex_rs}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
